envelope_adsr: RTL and testbench

ENVELOPE_ADSR -- requirements
Module: envelope_adsr

---
 rtl/envelope_adsr.sv | 116 +++++++++++
 tb/tb_envelope_adsr.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/envelope_adsr.sv
// ADSR envelope generator stepped by an external tick enable.
// Optional ENVELOPE_EXP_RELEASE_EN selects an exponential release curve.
module envelope_adsr #(
  parameter int LEVEL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               gate,
  input  logic [LEVEL_W-1:0] attack_rate,
  input  logic [LEVEL_W-1:0] decay_rate,
  input  logic [LEVEL_W-1:0] sustain_level,
  input  logic [LEVEL_W-1:0] release_rate,
  output logic [LEVEL_W-1:0] level,
  output logic [2:0]         state,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  localparam logic [LEVEL_W-1:0] MAX = '1;

  state_t             cur;
  state_t             nxt;
  logic [LEVEL_W-1:0] lvl_nxt;
  logic               gate_q;
  logic               rise;
  logic               fall;
  logic [LEVEL_W:0]   sum;
  logic [LEVEL_W-1:0] rel_step;

  assign rise  = gate & ~gate_q;
  assign fall  = ~gate & gate_q;
  assign sum   = {1'b0, level} + {1'b0, attack_rate};
  assign state = cur;

`ifdef ENVELOPE_EXP_RELEASE_EN
  logic [LEVEL_W-1:0] shifted;
  assign shifted  = level >> release_rate[2:0];
  assign rel_step = (shifted == '0) ? LEVEL_W'(1) : shifted;
`else
  assign rel_step = release_rate;
`endif

  // Next state and level: gate edges win over tick steps
  always_comb begin
    nxt     = cur;
    lvl_nxt = level;
    if (rise) begin
      nxt = S_ATTACK;
    end else if (fall) begin
      if (cur == S_ATTACK || cur == S_DECAY || cur == S_SUSTAIN)
        nxt = S_RELEASE;
    end else if (tick) begin
      unique case (cur)
        S_IDLE: begin
          lvl_nxt = '0;
        end
        S_ATTACK: begin
          if (sum >= {1'b0, MAX}) begin
            lvl_nxt = MAX;
            nxt     = S_DECAY;
          end else begin
            lvl_nxt = sum[LEVEL_W-1:0];
          end
        end
        S_DECAY: begin
          if (level <= sustain_level ||
              level - sustain_level <= decay_rate) begin
            lvl_nxt = sustain_level;
            nxt     = S_SUSTAIN;
          end else begin
            lvl_nxt = level - decay_rate;
          end
        end
        S_SUSTAIN: begin
          lvl_nxt = sustain_level;
        end
        S_RELEASE: begin
          if (level <= rel_step) begin
            lvl_nxt = '0;
            nxt     = S_IDLE;
          end else begin
            lvl_nxt = level - rel_step;
          end
        end
        default: begin
          lvl_nxt = '0;
          nxt     = S_IDLE;
        end
      endcase
    end
  end

  // State, level, busy and gate history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cur    <= S_IDLE;
      level  <= '0;
      busy   <= 1'b0;
      gate_q <= 1'b0;
    end else begin
      cur    <= nxt;
      level  <= lvl_nxt;
      busy   <= (nxt != S_IDLE);
      gate_q <= gate;
    end
  end

endmodule

// File: tb/tb_envelope_adsr.sv
// Directed scoreboard bench for envelope_adsr (LEVEL_W=8).
// Expected level/state per cycle are queued and popped after each edge.
module tb_envelope_adsr;

  typedef struct packed {
    logic [7:0] lv;
    logic [2:0] st;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       gate;
  logic [7:0] attack_rate;
  logic [7:0] decay_rate;
  logic [7:0] sustain_level;
  logic [7:0] release_rate;
  logic [7:0] level;
  logic [2:0] state;
  logic       busy;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  envelope_adsr #(.LEVEL_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .tick(tick),
    .gate(gate),
    .attack_rate(attack_rate),
    .decay_rate(decay_rate),
    .sustain_level(sustain_level),
    .release_rate(release_rate),
    .level(level),
    .state(state),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, input logic t, input logic g,
                     input int el, input int es);
    exp_t e;
    rst  = r;
    tick = t;
    gate = g;
    q.push_back({8'(el), 3'(es)});
    @(posedge clk);
    #1;
    cyc_n++;
    e = q.pop_front();
    total++;
    assert (level === e.lv) else begin
      bad++;
      $error("FAIL level cyc=%0d got=%0d want=%0d", cyc_n, level, e.lv);
    end
    total++;
    assert (state === e.st) else begin
      bad++;
      $error("FAIL state cyc=%0d got=%0d want=%0d", cyc_n, state, e.st);
    end
    total++;
    assert (busy === (e.st != 3'd0)) else begin
      bad++;
      $error("FAIL busy cyc=%0d got=%0b want=%0b", cyc_n, busy,
             e.st != 3'd0);
    end
  endtask

  // One tick cycle followed by three quiet cycles holding the result
  task automatic tk(input logic g, input int el, input int es);
    cyc(1'b0, 1'b1, g, el, es);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, g, el, es);
  endtask

  initial begin
    attack_rate   = 8'd64;
    decay_rate    = 8'd16;
    sustain_level = 8'd128;
`ifdef ENVELOPE_EXP_RELEASE_EN
    release_rate  = 8'd2;
`else
    release_rate  = 8'd32;
`endif
    // reset, tick ignored in IDLE
    cyc(1'b1, 1'b1, 1'b0, 0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0, 0);
    // attack / decay / sustain
    cyc(1'b0, 1'b0, 1'b1, 0, 1);
    tk(1'b1, 64, 1);
    tk(1'b1, 128, 1);
    tk(1'b1, 192, 1);
    tk(1'b1, 255, 2);
    tk(1'b1, 239, 2);
    tk(1'b1, 223, 2);
    tk(1'b1, 207, 2);
    tk(1'b1, 191, 2);
    tk(1'b1, 175, 2);
    tk(1'b1, 159, 2);
    tk(1'b1, 143, 2);
    tk(1'b1, 128, 3);
    tk(1'b1, 128, 3);
    sustain_level = 8'd100;
    tk(1'b1, 100, 3);
    sustain_level = 8'd128;
    tk(1'b1, 128, 3);
    // release then retrigger at 96
    cyc(1'b0, 1'b0, 1'b0, 128, 4);
    tk(1'b0, 96, 4);
    cyc(1'b0, 1'b0, 1'b1, 96, 1);
    tk(1'b1, 160, 1);
    tk(1'b1, 224, 1);
    tk(1'b1, 255, 2);
    decay_rate = 8'd127;
    tk(1'b1, 128, 3);
    // fall colliding with tick in SUSTAIN
`ifdef ENVELOPE_EXP_RELEASE_EN
    release_rate = 8'd1;
    cyc(1'b0, 1'b1, 1'b0, 128, 4);
    tk(1'b0, 64, 4);
    tk(1'b0, 32, 4);
    tk(1'b0, 16, 4);
    tk(1'b0, 8, 4);
    tk(1'b0, 4, 4);
    tk(1'b0, 2, 4);
    tk(1'b0, 1, 4);
    tk(1'b0, 0, 0);
`else
    cyc(1'b0, 1'b1, 1'b0, 128, 4);
    tk(1'b0, 96, 4);
    tk(1'b0, 64, 4);
    tk(1'b0, 32, 4);
    tk(1'b0, 0, 0);
`endif
    tk(1'b0, 0, 0);
    // rate-0 holds, decay to 200, reset mid-envelope with gate high
    attack_rate = 8'd0;
    cyc(1'b0, 1'b0, 1'b1, 0, 1);
    tk(1'b1, 0, 1);
    tk(1'b1, 0, 1);
    attack_rate = 8'd255;
    tk(1'b1, 255, 2);
    decay_rate = 8'd0;
    tk(1'b1, 255, 2);
    decay_rate = 8'd55;
    tk(1'b1, 200, 2);
    cyc(1'b1, 1'b1, 1'b1, 0, 0);
    cyc(1'b0, 1'b0, 1'b1, 0, 1);
    // decay entered at or below sustain, then release rate 0
    tk(1'b1, 255, 2);
    sustain_level = 8'd255;
    tk(1'b1, 255, 3);
    release_rate = 8'd0;
    cyc(1'b0, 1'b0, 1'b0, 255, 4);
`ifdef ENVELOPE_EXP_RELEASE_EN
    tk(1'b0, 0, 0);
`else
    tk(1'b0, 255, 4);
    tk(1'b0, 255, 4);
`endif
    cyc(1'b1, 1'b0, 1'b0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
